// File: rtl/mux_scan_ctrl_pkg.sv
// Shared types and widths for the mux select sequencer.
package mux_scan_pkg;

  typedef enum logic [1:0] {IDLE, SETTLE, DONE} scan_state_t;

  localparam int DWELL_W = 4;

endpackage

// File: rtl/mux_scan_ctrl_if.sv
// Scan request, mux-tree select/sample and result handshake bundle.
interface mux_scan_ctrl_if #(parameter int N_IN = 16);
  localparam int SEL_W = $clog2(N_IN);

  logic             start;
  logic [N_IN-1:0]  chan_mask;
  logic [SEL_W-1:0] sel;
  logic             mux_q;
  logic             busy;
  logic [N_IN-1:0]  out_data;
  logic             out_valid;
  logic             out_ready;

  modport master (
    input  start, chan_mask, mux_q, out_ready,
    output sel, busy, out_data, out_valid
  );

  modport slave (
    output start, chan_mask, mux_q, out_ready,
    input  sel, busy, out_data, out_valid
  );
endinterface

// File: rtl/mux_scan_ctrl_next_chan_find.sv
// Lowest set mask bit strictly above cur, or lowest set bit overall when first=1.
import mux_scan_pkg::*;

module next_chan_find #(
  parameter int N_IN  = 16,
  parameter int SEL_W = $clog2(N_IN)
) (
  input  logic [N_IN-1:0]  mask,
  input  logic [SEL_W-1:0] cur,
  input  logic             first,
  output logic [SEL_W-1:0] nxt,
  output logic             found
);

  // Descending walk so the lowest qualifying index is the last one written.
  always_comb begin
    nxt   = '0;
    found = 1'b0;
    for (int i = N_IN - 1; i >= 0; i--) begin
      if (mask[i] && (first || (SEL_W'(i) > cur))) begin
        nxt   = SEL_W'(i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux_scan_ctrl.sv
// Select sequencer: walks sel over enabled channels, samples mux_q after a
// settle dwell, and presents the packed word on a valid/ready handshake.
import mux_scan_pkg::*;

module mux_scan_ctrl #(
  parameter int N_IN  = 16,
  parameter int DWELL = 2
) (
  input  logic           clk,
  input  logic           rst,
  mux_scan_ctrl_if.master bus
);

  localparam int SEL_W = $clog2(N_IN);

  scan_state_t       state_q, state_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic [N_IN-1:0]   mask_q, mask_d;
  logic [N_IN-1:0]   data_q, data_d;
  logic              vld_q, vld_d;

  logic [SEL_W-1:0]  first_idx, next_idx;
  logic              first_found, next_found;

  next_chan_find #(.N_IN(N_IN), .SEL_W(SEL_W)) u_first (
    .mask  (bus.chan_mask),
    .cur   ('0),
    .first (1'b1),
    .nxt   (first_idx),
    .found (first_found)
  );

  next_chan_find #(.N_IN(N_IN), .SEL_W(SEL_W)) u_next (
    .mask  (mask_q),
    .cur   (sel_q),
    .first (1'b0),
    .nxt   (next_idx),
    .found (next_found)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sel_q   <= '0;
      cnt_q   <= '0;
      mask_q  <= '0;
      data_q  <= '0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      mask_q  <= mask_d;
      data_q  <= data_d;
      vld_q   <= vld_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    mask_d  = mask_q;
    data_d  = data_q;
    vld_d   = vld_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          mask_d = bus.chan_mask;
          data_d = '0;
          if (first_found) begin
            sel_d   = first_idx;
            cnt_d   = DWELL_W'(DWELL);
            state_d = SETTLE;
          end else begin
            state_d = DONE;
          end
        end
      end
      SETTLE: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - DWELL_W'(1);
        end else begin
          data_d[sel_q] = bus.mux_q;
          if (next_found) begin
            sel_d = next_idx;
            cnt_d = DWELL_W'(DWELL);
          end else begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        // valid is registered one cycle after entering DONE
        if (vld_q && bus.out_ready) begin
          vld_d   = 1'b0;
          state_d = IDLE;
        end else begin
          vld_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.sel       = sel_q;
    bus.busy      = (state_q != IDLE);
    bus.out_data  = data_q;
    bus.out_valid = vld_q;
  end

endmodule
